// File: rtl/sound_clip_player.sv
// rtl/sound_clip_player.sv - plays one of four ROM audio clips into Audio_Controller at CLOCK_50/CLK_DIV
// Optional replay-on-end port 'loop' enabled by defining SOUND_CLIP_PLAYER_LOOP_EN.
module sound_clip_player #(
  parameter int ADDR_W    = 18,
  parameter int DATA_W    = 6,
  parameter int CLK_DIV   = 1200,
  parameter int CLIP0_END = 16395,
  parameter int CLIP1_END = 66982,
  parameter int CLIP2_END = 83254,
  parameter int CLIP3_END = 137138
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              play_req,
  input  logic [1:0]        clip_id,
  input  logic              stop,
`ifdef SOUND_CLIP_PLAYER_LOOP_EN
  input  logic              loop,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  input  logic              audio_out_allowed,
  output logic              write_audio_out,
  output logic [31:0]       left_channel_audio_out,
  output logic [31:0]       right_channel_audio_out,
  output logic              busy,
  output logic              clip_done,
  output logic [7:0]        underrun_cnt
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_WAIT, S_PUSH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [7:0]          under_q, under_d;
  logic                done_q, done_d;
  logic [ADDR_W-1:0]   sel_start, sel_end;
  logic                tick, busy_w, loop_en, write_w;

`ifdef SOUND_CLIP_PLAYER_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign busy_w = (state_q != S_IDLE);
  assign tick   = (div_q == DIV_W'(CLK_DIV - 1));

  // Clips are packed back to back: each starts one past the previous end.
  always_comb begin
    sel_start = '0;
    sel_end   = ADDR_W'(CLIP0_END);
    unique case (clip_id)
      2'd0: begin sel_start = '0;                       sel_end = ADDR_W'(CLIP0_END); end
      2'd1: begin sel_start = ADDR_W'(CLIP0_END + 1);   sel_end = ADDR_W'(CLIP1_END); end
      2'd2: begin sel_start = ADDR_W'(CLIP1_END + 1);   sel_end = ADDR_W'(CLIP2_END); end
      2'd3: begin sel_start = ADDR_W'(CLIP2_END + 1);   sel_end = ADDR_W'(CLIP3_END); end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    start_d  = start_q;
    end_d    = end_q;
    sample_d = sample_q;
    done_d   = 1'b0;
    write_w  = 1'b0;
    under_d  = under_q;
    div_d    = busy_w ? (tick ? '0 : div_q + DIV_W'(1)) : '0;

    if (state_q == S_PUSH && tick && !audio_out_allowed && under_q != 8'hFF)
      under_d = under_q + 8'd1;

    if (stop) begin
      if (busy_w) begin
        state_d = S_IDLE;
        addr_d  = '0;
      end
    end else if (play_req) begin
      state_d  = S_FETCH;
      addr_d   = sel_start;
      start_d  = sel_start;
      end_d    = sel_end;
      sample_d = '0;
      div_d    = '0;
    end else begin
      unique case (state_q)
        S_FETCH: state_d = S_LOAD;
        S_LOAD: begin
          sample_d = rom_q;
          state_d  = S_WAIT;
        end
        S_WAIT: if (tick) state_d = S_PUSH;
        S_PUSH: begin
          if (audio_out_allowed) begin
            write_w = 1'b1;
            if (addr_q == end_q) begin
              done_d = 1'b1;
              if (loop_en) begin
                addr_d  = start_q;
                state_d = S_FETCH;
              end else begin
                addr_d  = '0;
                state_d = S_IDLE;
              end
            end else begin
              addr_d  = addr_q + ADDR_W'(1);
              state_d = S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      start_q  <= '0;
      end_q    <= '0;
      sample_q <= '0;
      div_q    <= '0;
      under_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      start_q  <= start_d;
      end_q    <= end_d;
      sample_q <= sample_d;
      div_q    <= div_d;
      under_q  <= under_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr                = addr_q;
  assign write_audio_out         = write_w;
  assign left_channel_audio_out  = busy_w ? {sample_q, {(32-DATA_W){1'b0}}} : 32'd0;
  assign right_channel_audio_out = 32'd0;
  assign busy                    = busy_w;
  assign clip_done               = done_q;
  assign underrun_cnt            = under_q;

endmodule
